mem_write_sequencer: RTL and testbench
======================================

Name: mem_write_sequencer

Overview:
Write-side sequencer for the memory-to-memory transfer path. It takes words leaving the dff pipeline register (DOut2) and writes them into the destination memory at consecutive addresses. It buffers up to two words to absorb destination back-pressure, counts words against a programmed length, and reports completion. It is the consumer end of the read→register→write chain.

Parameters:
DATA_W, 8, width of transferred word (matches DOut2)
ADDR_W, 4, destination address width; addresses wrap modulo 2^ADDR_W

Ports:
clock  input  1  system clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  launch transfer; sampled only in IDLE
base_addr  input  ADDR_W  first destination address, latched on start
word_count  input  ADDR_W+1  number of words to write (0..2^ADDR_W), latched on start
DOut2  input  DATA_W  data word from the dff stage
din_valid  input  1  DOut2 holds a valid word
din_ready  output  1  sequencer accepts DOut2 this cycle
mem_busy  input  1  destination cannot take a write this cycle
wr_en  output  1  destination write strobe
wr_addr  output  ADDR_W  destination address
wr_data  output  DATA_W  destination write data
busy  output  1  transfer in progress (state != IDLE)
done  output  1  one-cycle completion pulse
words_written  output  ADDR_W+1  writes issued in the current or last transfer

Behaviour:
- Clock and reset: one clock is used. reset_n is asynchronous and active-low.
- Reset effects: state=IDLE, 2-entry buffer emptied, all counters 0. din_ready, wr_en, wr_addr, wr_data, busy, done and words_written are all 0.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE + start:
  - Latch base_addr and word_count; clear accepted and written counters.
  - Next state is RUN, or DONE if word_count==0.
  - start is ignored in every other state.
- din_ready = (state==RUN) && occupancy<2 && accepted<word_count.
  - It uses registered occupancy only. With a full buffer, din_ready=0 even if a pop occurs in the same cycle.
- Accept: when din_valid && din_ready, DOut2 is pushed at the clock edge and accepted increments.
- Move to FLUSH: RUN goes to FLUSH at the edge where accepted reaches word_count.
- wr_en = occupancy>0 && !mem_busy && state in {RUN, FLUSH}.
  - wr_data = buffer head.
  - wr_addr = (base + words_written) mod 2^ADDR_W.
  - On wr_en, pop the head and increment words_written.
  - wr_data and wr_addr hold their last values when wr_en=0.
- Latency: a word accepted at edge N drives wr_en in the cycle after edge N if mem_busy=0. Sustained throughput is 1 word/cycle.
- Simultaneous push and pop: occupancy stays unchanged and order is preserved (FIFO).
- Move to DONE: FLUSH (or RUN) goes to DONE at the edge where words_written reaches word_count.
- DONE: done=1 for exactly one cycle, then IDLE.
- words_written keeps its value until the next start.
- busy=1 in RUN, FLUSH and DONE.
- Address wrap: the counter rolls from 2^ADDR_W-1 to 0 with no error.
- din_valid outside RUN, or after the count is reached, is ignored. No data is stored.
- Reset mid-transfer: immediately returns to the reset state. Buffered words are discarded and no further wr_en is issued.

Test Plan:
1. base_addr=3, word_count=4, DOut2=AA,55,FF,00 on consecutive cycles, din_valid=1, mem_busy=0:
   - wr_en on 4 consecutive cycles, starting one cycle after the first accept.
   - Writes are (3,AA), (4,55), (5,FF), (6,00).
   - done pulses once, the cycle after the last write.
   - words_written=4, busy returns to 0.
2. word_count=0, start: no din_ready and no wr_en; done pulses exactly once; words_written=0.
3. base_addr=0, word_count=6, mem_busy=1 for 4 cycles after the first write:
   - din_ready drops once 2 words are buffered.
   - All 6 words are written to addresses 0..5 in order, with no duplicates or losses.
4. base_addr=14, word_count=4: addresses are 14, 15, 0, 1.
5. reset_n pulsed low after 2 of 5 writes:
   - wr_en, din_ready, busy and done go to 0 asynchronously.
   - A fresh start with base_addr=8, word_count=2 then writes correctly to 8 and 9.
6. start asserted during RUN, and din_valid held after word_count reached:
   - Latched parameters are unchanged.
   - din_ready=0, so no extra write occurs.

Source files
------------

// File: rtl/mem_write_sequencer_if.sv
// mem_write_sequencer_if: data-in handshake from the dff stage and destination memory write bus
interface mem_write_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] DOut2;
    logic              din_valid;
    logic              din_ready;
    logic              mem_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  DOut2, din_valid, mem_busy,
        output din_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output DOut2, din_valid, mem_busy,
        input  din_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/mem_write_sequencer.sv
// mem_write_sequencer: buffers words from the dff stage (2-deep FIFO) and writes them to consecutive destination addresses
module mem_write_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    mem_write_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       words_written
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] base, last_addr;
    logic [ADDR_W:0]   cnt, accepted, accepted_n, written_n;
    logic [DATA_W-1:0] fifo [2];
    logic [DATA_W-1:0] last_data;
    logic [1:0]        occ;
    logic              push, pop;

    // ready looks only at registered occupancy, so a full buffer stalls even while popping
    assign bus.din_ready = state == RUN && occ < 2'd2 && accepted < cnt;
    assign push          = bus.din_valid && bus.din_ready;
    assign pop           = occ != 2'd0 && !bus.mem_busy && (state == RUN || state == FLUSH);
    assign bus.wr_en     = pop;
    assign bus.wr_data   = pop ? fifo[0] : last_data;
    assign bus.wr_addr   = pop ? base + words_written[ADDR_W-1:0] : last_addr;
    assign accepted_n    = accepted + (ADDR_W+1)'(push);
    assign written_n     = words_written + (ADDR_W+1)'(pop);
    assign busy          = state != IDLE;
    assign done          = state == DONE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? (word_count == '0 ? DONE : RUN) : IDLE;
            RUN:     state_n = written_n == cnt ? DONE : (accepted_n == cnt ? FLUSH : RUN);
            FLUSH:   state_n = written_n == cnt ? DONE : FLUSH;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            base          <= '0;
            cnt           <= '0;
            accepted      <= '0;
            words_written <= '0;
            occ           <= '0;
            fifo[0]       <= '0;
            fifo[1]       <= '0;
            last_addr     <= '0;
            last_data     <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                base          <= base_addr;
                cnt           <= word_count;
                accepted      <= '0;
                words_written <= '0;
            end else begin
                accepted      <= accepted_n;
                words_written <= written_n;
            end
            occ <= occ + 2'(push) - 2'(pop);
            if (pop) begin
                fifo[0]   <= fifo[1];
                last_addr <= bus.wr_addr;
                last_data <= fifo[0];
            end
            // a push lands behind the head unless the head is being drained in the same cycle
            if (push && occ == 2'd1 && !pop)
                fifo[1] <= bus.DOut2;
            else if (push)
                fifo[0] <= bus.DOut2;
        end
    end
endmodule

// File: tb/tb_mem_write_sequencer.sv
// tb_mem_write_sequencer: directed scenarios with a scoreboard of expected (address, data) writes
module tb_mem_write_sequencer;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] base_addr = '0;
    logic [4:0] word_count = '0;
    logic       busy, done;
    logic [4:0] words_written;

    mem_write_sequencer_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    mem_write_sequencer #(.DATA_W(8), .ADDR_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .base_addr(base_addr), .word_count(word_count), .bus(bus),
        .busy(busy), .done(done), .words_written(words_written)
    );

    always #5 clock = ~clock;

    int tests = 0, fails = 0;
    logic [11:0] sb [$];
    logic [11:0] e;
    logic [3:0]  sb_addr = '0;
    int cyc = 0, wr_cnt = 0, acc_cnt = 0, done_cnt = 0, rdy_cnt = 0, full_stall = 0;
    int first_acc = 0, first_wr = 0, last_wr = 0, done_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor: checks wr_en against the model occupancy, pops writes, pushes accepted words
    always @(negedge clock) begin
        cyc++;
        chk("wr_en_model", 32'(bus.wr_en), 32'(sb.size() > 0 && !bus.mem_busy && reset_n));
        chk("ready_full", 32'(bus.din_ready && sb.size() >= 2), 32'd0);
        if (bus.din_ready) rdy_cnt++;
        if (bus.din_valid && !bus.din_ready && sb.size() == 2) full_stall++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.wr_en) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e[11:8]));
                chk("wr_data", 32'(bus.wr_data), 32'(e[7:0]));
            end
            if (wr_cnt == 0) first_wr = cyc;
            last_wr = cyc;
            wr_cnt++;
        end
        if (bus.din_valid && bus.din_ready) begin
            sb.push_back({sb_addr, bus.DOut2});
            if (acc_cnt == 0) first_acc = cyc;
            acc_cnt++;
            sb_addr++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear();
        wr_cnt = 0; acc_cnt = 0; done_cnt = 0; rdy_cnt = 0; full_stall = 0;
    endtask

    task automatic do_start(input logic [3:0] b, input logic [4:0] n);
        clear();
        base_addr = b;
        word_count = n;
        sb_addr = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] w);
        int k = 0;
        bus.DOut2 = w;
        bus.din_valid = 1'b1;
        @(negedge clock);
        while (!bus.din_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("send_timeout", 32'(k < 50), 32'd1);
        tick();
        bus.din_valid = 1'b0;
    endtask

    task automatic finish_xfer(input logic [4:0] exp_ww, input int exp_wr);
        int k = 0;
        while (!done && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("done_seen", 32'(done), 32'd1);
        tick();
        tick();
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("words_written", 32'(words_written), 32'(exp_ww));
        chk("write_count", 32'(wr_cnt), 32'(exp_wr));
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bus.DOut2 = '0;
        bus.din_valid = 1'b0;
        bus.mem_busy = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(bus.din_ready), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_words", 32'(words_written), 32'd0);
        reset_n = 1'b1;
        tick();

        do_start(4'd3, 5'd4);
        send(8'hAA); send(8'h55); send(8'hFF); send(8'h00);
        finish_xfer(5'd4, 4);
        chk("lat_first_wr", 32'(first_wr - first_acc), 32'd1);
        chk("lat_back2back", 32'(last_wr - first_wr), 32'd3);
        chk("lat_done", 32'(done_cyc - last_wr), 32'd1);

        bus.DOut2 = 8'h5A;
        bus.din_valid = 1'b1;
        do_start(4'd7, 5'd0);
        finish_xfer(5'd0, 0);
        chk("zero_no_ready", 32'(rdy_cnt), 32'd0);
        bus.din_valid = 1'b0;

        do_start(4'd0, 5'd6);
        fork
            for (int i = 0; i < 6; i++) send(8'(8'h10 + i));
            begin
                int k = 0;
                @(negedge clock);
                while (!bus.wr_en && k < 50) begin
                    @(negedge clock);
                    k++;
                end
                chk("first_wr_timeout", 32'(k < 50), 32'd1);
                @(posedge clock);
                #1;
                bus.mem_busy = 1'b1;
                repeat (4) tick();
                bus.mem_busy = 1'b0;
            end
        join
        finish_xfer(5'd6, 6);
        chk("ready_drops", 32'(full_stall > 0), 32'd1);

        do_start(4'd14, 5'd4);
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        finish_xfer(5'd4, 4);
        chk("addr_hold", 32'(bus.wr_addr), 32'd1);
        chk("data_hold", 32'(bus.wr_data), 32'hC4);

        do_start(4'd2, 5'd5);
        send(8'hD1); send(8'hD2); send(8'hD3);
        bus.din_valid = 1'b0;
        chk("pre_reset_writes", 32'(wr_cnt), 32'd2);
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_ready", 32'(bus.din_ready), 32'd0);
        chk("arst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("arst_words", 32'(words_written), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("no_write_after_rst", 32'(wr_cnt), 32'd2);
        do_start(4'd8, 5'd2);
        send(8'hE8); send(8'hE9);
        finish_xfer(5'd2, 2);

        do_start(4'd2, 5'd2);
        send(8'hA1);
        start = 1'b1;
        base_addr = 4'd9;
        word_count = 5'd7;
        send(8'hA2);
        start = 1'b0;
        bus.DOut2 = 8'h77;
        bus.din_valid = 1'b1;
        @(negedge clock);
        chk("ready_after_count", 32'(bus.din_ready), 32'd0);
        finish_xfer(5'd2, 2);
        chk("restart_ignored_ready", 32'(rdy_cnt), 32'd2);
        bus.din_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
